// File: rtl/lockstep_pkg.sv
// rtl/lockstep_pkg.sv - shared types, helpers and parameter limits for the lockstep comparator
// Contents: state_t encoding, clog2 helper, params_ok range check.
package lockstep_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    CHECK  = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam int MAX_NCH    = 16;
  localparam int MAX_DELAY  = 7;
  localparam int MAX_THRESH = 15;
  localparam int WARM_W     = 3;  // holds 0..MAX_DELAY
  localparam int RUN_W      = 4;  // holds 0..MAX_THRESH

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit params_ok(input int nch, input int w, input int delay,
                                   input int thresh, input int cnt_w);
    return (nch >= 1) && (nch <= MAX_NCH) &&
           (w >= 1) &&
           (delay >= 0) && (delay <= MAX_DELAY) &&
           (thresh >= 1) && (thresh <= MAX_THRESH) &&
           (cnt_w >= 1) && (cnt_w <= 32);
  endfunction

endpackage

// File: rtl/lockstep_delay_line.sv
// rtl/lockstep_delay_line.sv - fixed-length shift register aligning the master stream
// Ports: clk, reset (sync, active-high, clears valid bits only),
//        in_valid/in_data (master sample), out_valid/out_data (sample DELAY cycles later).
// DELAY = 0 degenerates to a wire.
module lockstep_delay_line #(
  parameter int DELAY = 2,
  parameter int DW    = 96
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  if (DELAY == 0) begin : g_wire
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_stages
    logic [DELAY-1:0] vld;
    logic [DW-1:0]    dat [DELAY];

    // Only the valid bits need a defined value after reset; stale data
    // behind a cleared valid is never compared.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld <= '0;
      end else begin
        vld[0] <= in_valid;
        for (int i = 1; i < DELAY; i++) vld[i] <= vld[i-1];
      end
    end

    always_ff @(posedge clk) begin
      dat[0] <= in_data;
      for (int i = 1; i < DELAY; i++) dat[i] <= dat[i-1];
    end

    assign out_valid = vld[DELAY-1];
    assign out_data  = dat[DELAY-1];
  end

endmodule

// File: rtl/lockstep_comparator.sv
// rtl/lockstep_comparator.sv - delayed master vs checker signature comparator with sticky fault
// Ports: clk, reset (sync, active-high)
//        m_valid/m_data     master signatures, channel i at [i*W +: W]
//        c_valid/c_data     checker signatures, DELAY cycles behind the master
//        clear              zeroes fault, fault_ch, err_count, run counter, mismatch_vec
//        mismatch_vec       per-channel result of the last compare slot
//        mismatch_now       OR of mismatch_vec
//        fault / fault_ch   sticky fault flag and accumulated channel mask
//        err_count          saturating count of mismatching compares
//        state              FSM state (WARMUP/CHECK/FAULT)
//        inj_req/inj_ch     only with LOCKSTEP_FAULT_INJECT_EN: flip bit 0 of the
//                           delayed master channel inj_ch for one compare
module lockstep_comparator
  import lockstep_pkg::*;
#(
  parameter  int NCH    = 3,
  parameter  int W      = 32,
  parameter  int DELAY  = 2,
  parameter  int THRESH = 1,
  parameter  int CNT_W  = 8,
  localparam int INJ_W  = (NCH > 1) ? clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m_valid,
  input  logic [NCH*W-1:0] m_data,
  input  logic             c_valid,
  input  logic [NCH*W-1:0] c_data,
  input  logic             clear,
  output logic [NCH-1:0]   mismatch_vec,
  output logic             mismatch_now,
  output logic             fault,
  output logic [NCH-1:0]   fault_ch,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state
`ifdef LOCKSTEP_FAULT_INJECT_EN
  ,
  input  logic             inj_req,
  input  logic [INJ_W-1:0] inj_ch
`endif
);

  localparam int DW = NCH * W;

  if (!params_ok(NCH, W, DELAY, THRESH, CNT_W)) begin : g_param_error
    $error("lockstep_comparator: parameter out of range");
  end

  state_t              cur_state;
  state_t              nxt_state;
  logic [WARM_W-1:0]   warm_cnt;
  logic [RUN_W-1:0]    run_cnt;

  logic                dly_valid;
  logic [DW-1:0]       dly_data;
  logic [DW-1:0]       cmp_master;
  logic [NCH-1:0]      cmp_vec;
  logic                cmp_fail;
  logic                slot;
  logic [RUN_W:0]      run_next;
  logic                hit_thresh;

  lockstep_delay_line #(
    .DELAY (DELAY),
    .DW    (DW)
  ) u_delay_line (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (m_valid),
    .in_data   (m_data),
    .out_valid (dly_valid),
    .out_data  (dly_data)
  );

`ifdef LOCKSTEP_FAULT_INJECT_EN
  // Out-of-range channel numbers match no channel and inject nothing.
  logic [DW-1:0] inj_mask;

  always_comb begin
    inj_mask = '0;
    for (int i = 0; i < NCH; i++) begin
      if (inj_req && (int'(inj_ch) == i)) inj_mask[i*W] = 1'b1;
    end
  end

  assign cmp_master = dly_data ^ inj_mask;
`else
  assign cmp_master = dly_data;
`endif

  // A single-sided valid is a sequence skew and flags every channel.
  always_comb begin
    cmp_vec = '1;
    if (dly_valid && c_valid) begin
      for (int i = 0; i < NCH; i++) begin
        cmp_vec[i] = (cmp_master[i*W +: W] != c_data[i*W +: W]);
      end
    end
  end

  assign cmp_fail   = |cmp_vec;
  assign slot       = (cur_state != WARMUP) && (dly_valid || c_valid);
  assign run_next   = {1'b0, run_cnt} + 1'b1;
  assign hit_thresh = slot && cmp_fail && (run_next == (RUN_W+1)'(THRESH));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) cur_state <= WARMUP;
    else       cur_state <= nxt_state;
  end

  // Next-state logic.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      WARMUP: begin
        // clear during warm-up keeps us here one more cycle; the counter
        // is parked at DELAY so the exit happens on the following cycle.
        if (!clear && (warm_cnt == WARM_W'(DELAY))) nxt_state = CHECK;
      end
      CHECK: begin
        if (clear)           nxt_state = CHECK;
        else if (hit_thresh) nxt_state = FAULT;
      end
      FAULT: begin
        if (clear) nxt_state = CHECK;
      end
      default: nxt_state = WARMUP;
    endcase
  end

  // Output logic.
  always_comb begin
    state        = cur_state;
    mismatch_now = |mismatch_vec;
  end

  // Warm-up counter: runs 0..DELAY once after reset, then parks.
  always_ff @(posedge clk) begin
    if (reset) begin
      warm_cnt <= '0;
    end else if ((cur_state == WARMUP) && (warm_cnt != WARM_W'(DELAY))) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  // Compare result, counters and sticky flags. clear beats a coincident
  // compare slot so the discarded result cannot leak into the fresh epoch.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      mismatch_vec <= '0;
      fault_ch     <= '0;
      err_count    <= '0;
      run_cnt      <= '0;
      fault        <= 1'b0;
    end else if (slot) begin
      mismatch_vec <= cmp_vec;
      fault_ch     <= fault_ch | cmp_vec;
      if (cmp_fail) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (run_cnt != '1)   run_cnt   <= run_cnt + 1'b1;
      end else begin
        run_cnt <= '0;
      end
      if ((cur_state == CHECK) && hit_thresh) fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lockstep_comparator.sv
// tb/tb_lockstep_comparator.sv - directed self-checking bench for lockstep_comparator
module tb_lockstep_comparator;

  localparam int NCH = 3;
  localparam int W   = 32;
  localparam int DW  = NCH * W;
  localparam logic [1:0] ST_WARMUP = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;
  localparam logic [DW-1:0] CX_NONE = '0;
  localparam logic [DW-1:0] CX_CH0  = 96'h1;
  localparam logic [DW-1:0] CX_CH1  = 96'h1_0000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          c_valid;
  logic [DW-1:0] c_data;
  logic          clear;
`ifdef LOCKSTEP_FAULT_INJECT_EN
  logic          inj_req;
  logic [1:0]    inj_ch;
`endif

  logic [NCH-1:0] a_mm, b_mm, a_fch, b_fch;
  logic           a_now, b_now, a_fault, b_fault;
  logic [7:0]     a_err, b_err;
  logic [1:0]     a_state, b_state;

  int n_checks = 0;
  int n_errors = 0;
  int tick = 0;
  logic          hv [0:2047];
  logic [DW-1:0] hd [0:2047];

  always #5 clk = ~clk;

  lockstep_comparator #(.NCH(NCH), .W(W), .DELAY(2), .THRESH(1), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_data(m_data),
    .c_valid(c_valid), .c_data(c_data), .clear(clear),
    .mismatch_vec(a_mm), .mismatch_now(a_now), .fault(a_fault), .fault_ch(a_fch),
    .err_count(a_err), .state(a_state)
`ifdef LOCKSTEP_FAULT_INJECT_EN
    , .inj_req(inj_req), .inj_ch(inj_ch)
`endif
  );

  lockstep_comparator #(.NCH(NCH), .W(W), .DELAY(2), .THRESH(3), .CNT_W(8)) u_b (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_data(m_data),
    .c_valid(c_valid), .c_data(c_data), .clear(clear),
    .mismatch_vec(b_mm), .mismatch_now(b_now), .fault(b_fault), .fault_ch(b_fch),
    .err_count(b_err), .state(b_state)
`ifdef LOCKSTEP_FAULT_INJECT_EN
    , .inj_req(inj_req), .inj_ch(inj_ch)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int t);
    return {~32'(t), 32'hDEADBEEF, 32'(t)};
  endfunction

  // One clock: master sample for this tick, checker replays the master
  // from two ticks earlier (optionally corrupted / suppressed).
  task automatic cyc(input bit mv, input logic [DW-1:0] cx, input bit cv_en, input bit clr);
    m_valid  = mv;
    m_data   = pat(tick);
    hv[tick] = mv;
    hd[tick] = pat(tick);
    if (tick >= 2) begin
      c_valid = hv[tick-2] & cv_en;
      c_data  = hd[tick-2] ^ cx;
    end else begin
      c_valid = 1'b0;
      c_data  = '0;
    end
    clear = clr;
    @(posedge clk);
    #1;
    tick++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [5:0] seq_mm;
    logic [5:0] seq_fault;
    reset   = 1'b1;
    m_valid = 1'b0;
    m_data  = '0;
    c_valid = 1'b0;
    c_data  = '0;
    clear   = 1'b0;
`ifdef LOCKSTEP_FAULT_INJECT_EN
    inj_req = 1'b0;
    inj_ch  = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_a_mm", a_mm, 0);
    check_eq("rst_a_now", a_now, 0);
    check_eq("rst_a_fault", a_fault, 0);
    check_eq("rst_a_fch", a_fch, 0);
    check_eq("rst_a_err", a_err, 0);
    check_eq("rst_a_state", a_state, ST_WARMUP);
    check_eq("rst_b_state", b_state, ST_WARMUP);

    // Warm-up: CHECK is reached on the third clock after reset release.
    reset = 1'b0;
    cyc(1, CX_NONE, 1, 0);
    check_eq("warm1_state", a_state, ST_WARMUP);
    cyc(1, CX_NONE, 1, 0);
    check_eq("warm2_state", a_state, ST_WARMUP);
    cyc(1, CX_NONE, 1, 0);
    check_eq("warm3_state", a_state, ST_CHECK);
    check_eq("warm3_b_state", b_state, ST_CHECK);

    // 100 identical samples.
    for (int i = 0; i < 100; i++) begin
      cyc(1, CX_NONE, 1, 0);
      check_eq("ident_a_now", a_now, 0);
      check_eq("ident_b_now", b_now, 0);
    end
    check_eq("ident_a_fault", a_fault, 0);
    check_eq("ident_a_err", a_err, 0);
    check_eq("ident_b_err", b_err, 0);

    // Single corrupted channel 1.
    cyc(1, CX_CH1, 1, 0);
    check_eq("ch1_a_mm", a_mm, 3'b010);
    check_eq("ch1_a_fault", a_fault, 1);
    check_eq("ch1_a_err", a_err, 1);
    check_eq("ch1_a_state", a_state, ST_FAULT);
    check_eq("ch1_b_mm", b_mm, 3'b010);
    check_eq("ch1_b_fault", b_fault, 0);
    check_eq("ch1_b_err", b_err, 1);
    cyc(1, CX_NONE, 1, 0);
    check_eq("ch1_a_mm_next", a_mm, 3'b000);
    check_eq("ch1_a_fault_sticky", a_fault, 1);
    check_eq("ch1_a_fch", a_fch, 3'b010);
    cyc(1, CX_NONE, 1, 1);
    check_eq("clr1_a_fault", a_fault, 0);
    check_eq("clr1_a_err", a_err, 0);
    check_eq("clr1_a_fch", a_fch, 0);
    check_eq("clr1_a_state", a_state, ST_CHECK);

    // THRESH=3: M M ok M M M.
    seq_mm    = 6'b111011;
    seq_fault = 6'b100000;
    for (int i = 0; i < 6; i++) begin
      cyc(1, seq_mm[i] ? CX_CH1 : CX_NONE, 1, 0);
      check_eq("thr_b_mm", b_mm, seq_mm[i] ? 3'b010 : 3'b000);
      check_eq("thr_b_fault", b_fault, seq_fault[i]);
    end
    check_eq("thr_b_err", b_err, 5);
    check_eq("thr_b_state", b_state, ST_FAULT);
    check_eq("thr_a_err", a_err, 5);
    check_eq("thr_a_fch", a_fch, 3'b010);
    cyc(1, CX_NONE, 1, 1);
    check_eq("clr2_b_state", b_state, ST_CHECK);
    check_eq("clr2_b_err", b_err, 0);

    // Skew: drain, idle, then a lone master pulse with checker silent.
    cyc(0, CX_NONE, 1, 0);
    cyc(0, CX_NONE, 1, 0);
    cyc(0, CX_NONE, 1, 0);
    check_eq("drain_a_mm", a_mm, 0);
    check_eq("drain_a_err", a_err, 0);
    cyc(1, CX_NONE, 0, 0);
    cyc(0, CX_NONE, 0, 0);
    cyc(0, CX_NONE, 0, 0);
    check_eq("skew_a_mm", a_mm, 3'b111);
    check_eq("skew_a_fch", a_fch, 3'b111);
    check_eq("skew_a_err", a_err, 1);
    check_eq("skew_a_fault", a_fault, 1);
    check_eq("skew_b_mm", b_mm, 3'b111);
    check_eq("skew_b_fault", b_fault, 0);
    cyc(0, CX_NONE, 0, 0);
    check_eq("hold_a_mm", a_mm, 3'b111);
    check_eq("hold_a_err", a_err, 1);
    check_eq("hold_b_err", b_err, 1);

    // Resume streams, then clear together with a mismatching compare in FAULT.
    cyc(1, CX_NONE, 1, 0);
    cyc(1, CX_NONE, 1, 0);
    cyc(1, CX_NONE, 1, 0);
    check_eq("resume_a_state", a_state, ST_FAULT);
    check_eq("resume_a_mm", a_mm, 0);
    cyc(1, CX_CH1, 1, 1);
    check_eq("clrmm_a_fault", a_fault, 0);
    check_eq("clrmm_a_err", a_err, 0);
    check_eq("clrmm_a_state", a_state, ST_CHECK);
    check_eq("clrmm_a_mm", a_mm, 0);
    check_eq("clrmm_a_fch", a_fch, 0);
    check_eq("clrmm_b_err", b_err, 0);

`ifdef LOCKSTEP_FAULT_INJECT_EN
    inj_req = 1'b1;
    inj_ch  = 2'd2;
    cyc(1, CX_NONE, 1, 0);
    inj_req = 1'b0;
    check_eq("inj_a_mm", a_mm, 3'b100);
    check_eq("inj_a_err", a_err, 1);
    cyc(1, CX_NONE, 1, 0);
    check_eq("inj_a_mm_next", a_mm, 3'b000);
    cyc(1, CX_NONE, 1, 1);
    inj_req = 1'b1;
    inj_ch  = 2'd3;
    cyc(1, CX_NONE, 1, 0);
    inj_req = 1'b0;
    check_eq("inj_oor_a_mm", a_mm, 3'b000);
    check_eq("inj_oor_a_err", a_err, 0);
`endif

    // err_count saturation.
    cyc(1, CX_NONE, 1, 1);
    for (int i = 0; i < 260; i++) cyc(1, CX_CH0, 1, 0);
    check_eq("sat_a_err", a_err, 8'd255);
    check_eq("sat_b_err", b_err, 8'd255);
    check_eq("sat_a_fch", a_fch, 3'b001);

    // Reset mid-operation.
    reset = 1'b1;
    cyc(1, CX_CH0, 1, 0);
    check_eq("mrst_a_state", a_state, ST_WARMUP);
    check_eq("mrst_a_err", a_err, 0);
    check_eq("mrst_a_fault", a_fault, 0);
    check_eq("mrst_a_mm", a_mm, 0);
    check_eq("mrst_a_fch", a_fch, 0);
    check_eq("mrst_b_err", b_err, 0);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
